// File: rtl/mem_wb_skid_buffer.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Define MEMWB_PERF_EN to add saturating stall/flush counters (stall_cnt, flush_cnt).
module mem_wb_skid_buffer #(
    parameter int DW = 32,
    parameter int AW = 5
`ifdef MEMWB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_jump,
    input  logic          in_regw,
    input  logic          in_memreg,
    input  logic [DW-1:0] in_memres,
    input  logic [DW-1:0] in_alures,
    input  logic [DW-1:0] in_jaddr,
    input  logic [AW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_jump,
    output logic          out_regw,
    output logic          out_memreg,
    output logic [DW-1:0] out_memres,
    output logic [DW-1:0] out_alures,
    output logic [DW-1:0] out_jaddr,
    output logic [AW-1:0] out_rd,
    output logic [DW-1:0] out_wbdata
`ifdef MEMWB_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef struct packed {
        logic          jump;
        logic          regw;
        logic          memreg;
        logic [DW-1:0] memres;
        logic [DW-1:0] alures;
        logic [DW-1:0] jaddr;
        logic [AW-1:0] rd;
    } beat_t;

    beat_t in_beat;
    beat_t h_q;
    beat_t s_q;
    logic  hv_q, hv_d;
    logic  sv_q, sv_d;
    logic  accept;
    logic  pop;
    logic  load_h;
    logic  load_s;
    logic  h_from_s;

    assign in_beat = '{jump:   in_jump,
                       regw:   in_regw,
                       memreg: in_memreg,
                       memres: in_memres,
                       alures: in_alures,
                       jaddr:  in_jaddr,
                       rd:     in_rd};

    // in_ready depends on registered state only, breaking the out_ready -> in_ready path.
    assign in_ready = ~sv_q;
    assign accept   = in_valid & ~sv_q;
    assign pop      = hv_q & out_ready;

    always_comb begin
        hv_d     = hv_q;
        sv_d     = sv_q;
        load_h   = 1'b0;
        load_s   = 1'b0;
        h_from_s = 1'b0;
        if (flush) begin
            hv_d = 1'b0;
            sv_d = 1'b0;
        end else if (pop && !accept) begin
            hv_d     = sv_q;
            sv_d     = 1'b0;
            load_h   = sv_q;
            h_from_s = sv_q;
        end else if (accept && (!hv_q || pop)) begin
            if (sv_q) begin
                load_h   = 1'b1;
                h_from_s = 1'b1;
                load_s   = 1'b1;
            end else begin
                load_h = 1'b1;
                hv_d   = 1'b1;
            end
        end else if (accept) begin
            load_s = 1'b1;
            sv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q <= 1'b0;
            sv_q <= 1'b0;
            h_q  <= '0;
            s_q  <= '0;
        end else begin
            hv_q <= hv_d;
            sv_q <= sv_d;
            if (load_h) h_q <= h_from_s ? s_q : in_beat;
            if (load_s) s_q <= in_beat;
        end
    end

    // Controls are qualified by hv so an empty buffer never triggers a write-back.
    assign out_valid  = hv_q;
    assign out_jump   = h_q.jump & hv_q;
    assign out_regw   = h_q.regw & hv_q;
    assign out_memreg = h_q.memreg & hv_q;
    assign out_memres = h_q.memres;
    assign out_alures = h_q.alures;
    assign out_jaddr  = h_q.jaddr;
    assign out_rd     = h_q.rd;
    assign out_wbdata = out_memreg ? h_q.memres : h_q.alures;

`ifdef MEMWB_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hv_q && !out_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (flush && (hv_q || sv_q) && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_buffer.sv
// Self-checking bench for mem_wb_skid_buffer: directed scenarios plus random traffic
// compared against a queue-based FIFO reference model.
module tb_mem_wb_skid_buffer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CNT_W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_jump;
    logic          in_regw;
    logic          in_memreg;
    logic [DW-1:0] in_memres;
    logic [DW-1:0] in_alures;
    logic [DW-1:0] in_jaddr;
    logic [AW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic          out_jump;
    logic          out_regw;
    logic          out_memreg;
    logic [DW-1:0] out_memres;
    logic [DW-1:0] out_alures;
    logic [DW-1:0] out_jaddr;
    logic [AW-1:0] out_rd;
    logic [DW-1:0] out_wbdata;
`ifdef MEMWB_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    mem_wb_skid_buffer #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_jump    (in_jump),
        .in_regw    (in_regw),
        .in_memreg  (in_memreg),
        .in_memres  (in_memres),
        .in_alures  (in_alures),
        .in_jaddr   (in_jaddr),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_jump   (out_jump),
        .out_regw   (out_regw),
        .out_memreg (out_memreg),
        .out_memres (out_memres),
        .out_alures (out_alures),
        .out_jaddr  (out_jaddr),
        .out_rd     (out_rd),
        .out_wbdata (out_wbdata)
`ifdef MEMWB_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    typedef struct {
        logic          jump;
        logic          regw;
        logic          memreg;
        logic [DW-1:0] memres;
        logic [DW-1:0] alures;
        logic [DW-1:0] jaddr;
        logic [AW-1:0] rd;
    } beat_t;

    // Reference: the buffer is a 2-deep FIFO; index 0 is what the outputs show.
    beat_t       mq[$];
    int unsigned stall_exp;
    int unsigned flush_exp;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [AW-1:0] rd, input logic [DW-1:0] alures,
                                      input logic [DW-1:0] memres, input logic memreg);
        beat_t b;
        b.jump   = rd[0];
        b.regw   = 1'b1;
        b.memreg = memreg;
        b.memres = memres;
        b.alures = alures;
        b.jaddr  = {alures[15:0], memres[15:0]};
        b.rd     = rd;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.jump   = 1'($urandom);
        b.regw   = 1'($urandom);
        b.memreg = 1'($urandom);
        b.memres = $urandom;
        b.alures = $urandom;
        b.jaddr  = $urandom;
        b.rd     = AW'($urandom);
        return b;
    endfunction

    task automatic compare_outputs();
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_jump", 64'(out_jump), 64'(mq[0].jump));
            chk("out_regw", 64'(out_regw), 64'(mq[0].regw));
            chk("out_memreg", 64'(out_memreg), 64'(mq[0].memreg));
            chk("out_memres", 64'(out_memres), 64'(mq[0].memres));
            chk("out_alures", 64'(out_alures), 64'(mq[0].alures));
            chk("out_jaddr", 64'(out_jaddr), 64'(mq[0].jaddr));
            chk("out_rd", 64'(out_rd), 64'(mq[0].rd));
            chk("out_wbdata", 64'(out_wbdata),
                64'(mq[0].memreg ? mq[0].memres : mq[0].alures));
        end else begin
            chk("empty_ctrl", {61'd0, out_jump, out_regw, out_memreg}, 64'd0);
        end
`ifdef MEMWB_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
        chk("flush_cnt", 64'(flush_cnt), 64'(flush_exp));
`endif
    endtask

    task automatic model_step(input logic v, input logic r, input logic f, input beat_t b);
        bit acc;
        bit pop;
        acc = v && (mq.size() < 2);
        pop = r && (mq.size() > 0);
        if (mq.size() > 0 && !r && stall_exp < (1 << CNT_W) - 1) stall_exp++;
        if (f && mq.size() > 0 && flush_exp < (1 << CNT_W) - 1) flush_exp++;
        if (f) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
    endtask

    // One cycle: check state at the negedge, drive new inputs, advance the model past the next posedge.
    task automatic tick(input logic v, input logic r, input logic f, input beat_t b);
        @(negedge clk);
        compare_outputs();
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_jump   = b.jump;
        in_regw   = b.regw;
        in_memreg = b.memreg;
        in_memres = b.memres;
        in_alures = b.alures;
        in_jaddr  = b.jaddr;
        in_rd     = b.rd;
        model_step(v, r, f, b);
    endtask

    beat_t idle_b;

    initial begin
        idle_b    = mk_beat('0, '0, '0, 1'b0);
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_jump   = 1'b0;
        in_regw   = 1'b0;
        in_memreg = 1'b0;
        in_memres = '0;
        in_alures = '0;
        in_jaddr  = '0;
        in_rd     = '0;
        stall_exp = 0;
        flush_exp = 0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_alures", 64'(out_alures), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate: each beat visible exactly one edge after it is accepted.
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b1, 1'b0, mk_beat(AW'(k), DW'(k * 16), DW'(k), 1'b0));
            #6;
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_rd", 64'(out_rd), 64'(k));
            chk("stream_alures", 64'(out_alures), 64'(k * 16));
        end
        tick(1'b0, 1'b1, 1'b0, idle_b);

        // Back-pressure: B lands in the skid register, then drains in order.
        tick(1'b1, 1'b1, 1'b0, mk_beat(5'd10, 32'hA0, 32'h0, 1'b0));
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd11, 32'hB0, 32'h0, 1'b0));
        #6;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_A", 64'(out_rd), 64'd10);
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd12, 32'hC0, 32'h0, 1'b0));
        tick(1'b0, 1'b1, 1'b0, idle_b);
        #6;
        chk("bp_head_B", 64'(out_rd), 64'd11);
        tick(1'b0, 1'b1, 1'b0, idle_b);

        // Flush with both entries full, then flush while a beat is accepted.
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd20, 32'h200, 32'h0, 1'b0));
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd21, 32'h210, 32'h0, 1'b0));
        tick(1'b1, 1'b1, 1'b1, mk_beat(5'd22, 32'h220, 32'h0, 1'b0));
        #6;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd23, 32'h230, 32'h0, 1'b0));
        tick(1'b1, 1'b1, 1'b1, mk_beat(5'd24, 32'h240, 32'h0, 1'b0));
        tick(1'b0, 1'b1, 1'b0, idle_b);
        #6;
        chk("flush_drop", 64'(out_valid), 64'd0);

        // Write-back data select.
        tick(1'b1, 1'b1, 1'b0, mk_beat(5'd3, 32'h1234, 32'hDEADBEEF, 1'b1));
        #6;
        chk("wb_mem", 64'(out_wbdata), 64'hDEADBEEF);
        tick(1'b1, 1'b1, 1'b0, mk_beat(5'd4, 32'h1234, 32'hDEADBEEF, 1'b0));
        #6;
        chk("wb_alu", 64'(out_wbdata), 64'h1234);
        tick(1'b0, 1'b1, 1'b0, idle_b);

        // Asynchronous reset with both entries held, asserted between clock edges.
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd7, 32'h70, 32'h0, 1'b0));
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd8, 32'h80, 32'h0, 1'b0));
        @(negedge clk);
        compare_outputs();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_regw", 64'(out_regw), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        stall_exp = 0;
        flush_exp = 0;

        // Counter scenario: five stalled cycles, then one flush of a held entry.
        tick(1'b1, 1'b0, 1'b0, mk_beat(5'd9, 32'h90, 32'h0, 1'b0));
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, idle_b);
`ifdef MEMWB_PERF_EN
        #6;
        chk("perf_stall5", 64'(stall_cnt), 64'd5);
`endif
        tick(1'b0, 1'b0, 1'b1, idle_b);
`ifdef MEMWB_PERF_EN
        #6;
        chk("perf_flush1", 64'(flush_cnt), 64'd1);
`endif
        tick(1'b0, 1'b1, 1'b0, idle_b);

        // Random traffic against the FIFO model.
        for (int i = 0; i < 400; i++) begin
            tick(logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 4) < 3),
                 logic'($urandom_range(0, 19) == 0),
                 rand_beat());
        end
        @(negedge clk);
        compare_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
